// File: rtl/mux_tsel_sched.sv
// Round-robin scheduler sharing one temporal (rising-edge) mux datapath between requesters.
// Optional build macro MUX_SCHED_FIXED_PRIO_EN selects fixed priority (lowest index wins).
module mux_tsel_sched #(
  parameter int NUM_REQ           = 4,
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int BUS_WIDTH         = 8,
  parameter int CLEAR_CYCLES      = 2,
  localparam int DW = $clog2(GAMMA_CYCLE_WIDTH) + 1,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   aclk,
  input  logic                   grst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*DW-1:0]  req_delay,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   mux_rst,
  output logic                   select_line,
  output logic [DW-1:0]          gamma_cnt,
  input  logic [BUS_WIDTH-1:0]   mux_y,
  output logic                   rsp_valid,
  output logic [IW-1:0]          rsp_id,
  output logic [BUS_WIDTH-1:0]   rsp_data
);

  localparam int CW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [DW-1:0] GCNT_LAST = DW'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [CW-1:0] CLR_LOAD  = CW'(CLEAR_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CAPTURE, S_CLEAR} state_t;

  state_t               r_state, w_state_nxt;
  logic [NUM_REQ-1:0]   r_ready, w_ready_nxt;
  logic                 r_mux_rst, w_mux_rst_nxt;
  logic                 r_sel, w_sel_nxt;
  logic [DW-1:0]        r_gcnt, w_gcnt_nxt, w_gcnt_inc;
  logic [CW-1:0]        r_clr, w_clr_nxt;
  logic                 r_rsp_valid, w_rsp_valid_nxt;
  logic [IW-1:0]        r_rsp_id;
  logic [BUS_WIDTH-1:0] r_rsp_data;
  logic [IW-1:0]        r_rr_ptr, r_id;
  logic [DW-1:0]        r_delay;

  logic                 w_found, w_arb_en, w_grant;
  logic [IW-1:0]        w_gidx;
  logic [DW-1:0]        w_gdelay;

  // Search starts at rr_ptr and wraps; rr_ptr stays 0 in the fixed-priority build.
  always_comb begin : arb
    int j;
    j        = 0;
    w_found  = 1'b0;
    w_gidx   = '0;
    w_gdelay = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(r_rr_ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!w_found && req_valid[IW'(j)]) begin
        w_found  = 1'b1;
        w_gidx   = IW'(j);
        w_gdelay = req_delay[j*DW +: DW];
      end
    end
  end

  // Arbitrate in idle, or on the last clear cycle so the grant lands on the first idle cycle.
  assign w_arb_en   = ((r_state == S_IDLE) && (r_ready == '0)) ||
                      ((r_state == S_CLEAR) && (r_clr == '0));
  assign w_grant    = w_arb_en && w_found;
  assign w_gcnt_inc = r_gcnt + DW'(1);

  always_comb begin
    w_state_nxt     = r_state;
    w_ready_nxt     = '0;
    w_mux_rst_nxt   = 1'b1;
    w_sel_nxt       = 1'b0;
    w_gcnt_nxt      = '0;
    w_clr_nxt       = r_clr;
    w_rsp_valid_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_ready != '0) begin
          w_state_nxt   = S_RUN;
          w_mux_rst_nxt = 1'b0;
          w_sel_nxt     = (r_delay == '0);
        end
      end
      S_RUN: begin
        w_mux_rst_nxt = 1'b0;
        if (r_gcnt == GCNT_LAST) begin
          w_state_nxt = S_CAPTURE;
          w_gcnt_nxt  = r_gcnt;
          w_sel_nxt   = r_sel;
        end else begin
          w_gcnt_nxt = w_gcnt_inc;
          w_sel_nxt  = (w_gcnt_inc >= r_delay);
        end
      end
      S_CAPTURE: begin
        w_state_nxt     = S_CLEAR;
        w_rsp_valid_nxt = 1'b1;
        w_clr_nxt       = CLR_LOAD;
      end
      S_CLEAR: begin
        if (r_clr == '0) w_state_nxt = S_IDLE;
        else             w_clr_nxt   = r_clr - CW'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_grant) w_ready_nxt[w_gidx] = 1'b1;
  end

`ifndef MUX_SCHED_FIXED_PRIO_EN
  logic [IW-1:0] w_ptr_nxt;
  assign w_ptr_nxt = (w_gidx == IW'(NUM_REQ - 1)) ? '0 : w_gidx + IW'(1);
`endif

  always_ff @(posedge aclk or negedge grst) begin
    if (!grst) begin
      r_state     <= S_IDLE;
      r_ready     <= '0;
      r_mux_rst   <= 1'b1;
      r_sel       <= 1'b0;
      r_gcnt      <= '0;
      r_clr       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_rr_ptr    <= '0;
      r_id        <= '0;
      r_delay     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ready     <= w_ready_nxt;
      r_mux_rst   <= w_mux_rst_nxt;
      r_sel       <= w_sel_nxt;
      r_gcnt      <= w_gcnt_nxt;
      r_clr       <= w_clr_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      if (w_grant) begin
        r_id    <= w_gidx;
        r_delay <= w_gdelay;
`ifdef MUX_SCHED_FIXED_PRIO_EN
        r_rr_ptr <= '0;
`else
        r_rr_ptr <= w_ptr_nxt;
`endif
      end
      if (r_state == S_CAPTURE) begin
        r_rsp_id   <= r_id;
        r_rsp_data <= mux_y;
      end
    end
  end

  assign req_ready   = r_ready;
  assign mux_rst     = r_mux_rst;
  assign select_line = r_sel;
  assign gamma_cnt   = r_gcnt;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign rsp_data    = r_rsp_data;

endmodule
